// File: rtl/pi_walk_engine.sv
// pi_walk_engine: sequential Keccak pi-step permutation, one cell moved per clock
module pi_walk_engine #(
    parameter int LANE_W = 1,
    parameter int PASS_W = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  load,
    input  logic                  inverse,
    input  logic [PASS_W-1:0]     passes,
    input  logic [25*LANE_W-1:0]  state_in,
    output logic [25*LANE_W-1:0]  state_out,
    output logic                  busy,
    output logic                  done
);
    typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

    state_t             st_q, st_d;
    logic [LANE_W-1:0]  cell_q [25];
    logic [LANE_W-1:0]  carry_q;
    logic [2:0]         px_q, py_q, nx, ny;
    logic [4:0]         step_q, nidx, fsum, isum;
    logic [PASS_W-1:0]  pass_q;
    logic               inv_q, last_move;

    function automatic logic [2:0] mod5(input logic [4:0] v);
        return v >= 5'd20 ? 3'(v - 5'd20) :
               v >= 5'd15 ? 3'(v - 5'd15) :
               v >= 5'd10 ? 3'(v - 5'd10) :
               v >= 5'd5  ? 3'(v - 5'd5)  : 3'(v);
    endfunction

    for (genvar g = 0; g < 25; g++) begin : g_out
        assign state_out[g*LANE_W +: LANE_W] = cell_q[g];
    end

    // next walk position: forward (y, 2x+3y) or inverse (x+3y, x)
    always_comb begin
        fsum      = 5'd2 * {2'b00, px_q} + 5'd3 * {2'b00, py_q};
        isum      = {2'b00, px_q} + 5'd3 * {2'b00, py_q};
        nx        = inv_q ? mod5(isum) : py_q;
        ny        = inv_q ? px_q : mod5(fsum);
        nidx      = 5'd5 * {2'b00, nx} + {2'b00, ny};
        last_move = step_q == 5'd23;
    end

    // FSM next state and handshake outputs
    always_comb begin
        st_d = st_q;
        busy = st_q == RUN;
        done = st_q == FIN;
        if (st_q == IDLE && start)
            st_d = passes == '0 ? FIN : RUN;
        else if (st_q == RUN && last_move && pass_q == PASS_W'(1))
            st_d = FIN;
        else if (st_q == FIN)
            st_d = IDLE;
    end

    // state register, cell array and walk datapath
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st_q    <= IDLE;
            for (int k = 0; k < 25; k++) cell_q[k] <= '0;
            carry_q <= '0;
            px_q    <= 3'd1;
            py_q    <= 3'd0;
            step_q  <= '0;
            pass_q  <= '0;
            inv_q   <= 1'b0;
        end else begin
            st_q <= st_d;
            if (st_q == IDLE && start) begin
                inv_q   <= inverse;
                pass_q  <= passes;
                px_q    <= 3'd1;
                py_q    <= 3'd0;
                step_q  <= '0;
                carry_q <= load ? state_in[5*LANE_W +: LANE_W] : cell_q[5];
                if (load)
                    for (int k = 0; k < 25; k++) cell_q[k] <= state_in[k*LANE_W +: LANE_W];
            end else if (st_q == RUN) begin
                cell_q[nidx] <= carry_q;
                px_q         <= nx;
                py_q         <= ny;
                // closing move lands on (1,0); the value just written there seeds the next pass
                step_q       <= last_move ? 5'd0 : step_q + 5'd1;
                carry_q      <= last_move ? carry_q : cell_q[nidx];
                if (last_move) pass_q <= pass_q - PASS_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_pi_walk_engine.sv
// tb_pi_walk_engine: table, corner-case and random checks against a pi-step model
module tb_pi_walk_engine;
    localparam int LW = 8;
    localparam int W  = 25 * LW;

    typedef struct {
        logic         load;
        logic         inv;
        logic [4:0]   passes;
        logic [W-1:0] sin;
        logic [W-1:0] exp_out;
    } vec_t;

    logic         clk = 1'b0, rst = 1'b1, start = 1'b0, load = 1'b0, inverse = 1'b0;
    logic [4:0]   passes = '0;
    logic [W-1:0] state_in = '0, state_out;
    logic         busy, done;
    int           errors = 0, checks = 0;
    logic [W-1:0] ramp, ones, mstate;
    vec_t         vt [7];

    pi_walk_engine #(.LANE_W(LW), .PASS_W(5)) dut (
        .clk(clk), .rst(rst), .start(start), .load(load), .inverse(inverse),
        .passes(passes), .state_in(state_in), .state_out(state_out),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // whole-state permutation straight from the coordinate maps, applied n times
    function automatic logic [W-1:0] pi_model(input logic [W-1:0] s, input logic inv, input int n);
        logic [W-1:0] r;
        int tx, ty;
        for (int i = 0; i < n; i++) begin
            r = s;
            for (int x = 0; x < 5; x++)
                for (int y = 0; y < 5; y++) begin
                    tx = inv ? (x + 3*y) % 5 : y;
                    ty = inv ? x : (2*x + 3*y) % 5;
                    r[(5*tx + ty)*LW +: LW] = s[(5*x + y)*LW +: LW];
                end
            s = r;
        end
        return s;
    endfunction

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic run_op(input string name, input logic ld, input logic inv, input logic [4:0] np,
                          input logic [W-1:0] sin, input logic [W-1:0] exp);
        int cyc = 0, bcnt = 0;
        load = ld; inverse = inv; passes = np; state_in = sin; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        while (cyc < 24*32 + 8) begin
            @(negedge clk);
            cyc++;
            if (done) break;
            if (busy) bcnt++;
        end
        chk({name, " latency"}, W'(cyc), W'(24*np + 1));
        chk({name, " busy_cycles"}, W'(bcnt), W'(24*np));
        chk({name, " state"}, state_out, exp);
        @(negedge clk);
        chk({name, " done_pulse"}, W'({done, busy}), W'(0));
    endtask

    initial begin
        for (int k = 0; k < 25; k++) ramp[k*LW +: LW] = LW'(k);
        ones = '1;
        vt[0] = '{1'b1, 1'b0, 5'd1, W'(1) << (5*LW), W'(1) << (2*LW)};
        vt[1] = '{1'b1, 1'b0, 5'd1, ramp, pi_model(ramp, 1'b0, 1)};
        vt[2] = '{1'b0, 1'b1, 5'd1, '0, ramp};
        vt[3] = '{1'b1, 1'b0, 5'd24, ramp, ramp};
        vt[4] = '{1'b1, 1'b0, 5'd0, ones, ones};
        vt[5] = '{1'b1, 1'b1, 5'd3, ramp, pi_model(ramp, 1'b1, 3)};
        vt[6] = '{1'b0, 1'b0, 5'd3, ones, ramp};

        repeat (3) @(negedge clk);
        chk("reset_state", state_out, '0);
        chk("reset_flags", W'({busy, done}), W'(0));
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 7; i++) begin
            run_op($sformatf("vec%0d", i), vt[i].load, vt[i].inv, vt[i].passes, vt[i].sin, vt[i].exp_out);
        end
        mstate = ramp;

        begin : ignored_start
            int cyc = 0;
            load = 1'b1; inverse = 1'b0; passes = 5'd1; state_in = ramp; start = 1'b1;
            @(posedge clk);
            #1 start = 1'b0;
            while (cyc < 100) begin
                @(negedge clk);
                cyc++;
                start = cyc == 10;
                if (cyc == 10) begin load = 1'b1; inverse = 1'b1; passes = 5'd5; state_in = ~ramp; end
                if (done) break;
            end
            start = 1'b0;
            chk("ignored_start latency", W'(cyc), W'(25));
            chk("ignored_start state", state_out, pi_model(ramp, 1'b0, 1));
            @(negedge clk);
            chk("ignored_start done_pulse", W'(done), W'(0));
        end

        begin : mid_reset
            int cyc = 0, dcnt = 0;
            load = 1'b1; inverse = 1'b0; passes = 5'd2; state_in = ramp; start = 1'b1;
            @(posedge clk);
            #1 start = 1'b0;
            repeat (12) begin @(negedge clk); cyc++; end
            rst = 1'b1;
            #1;
            chk("mid_reset state", state_out, '0);
            chk("mid_reset flags", W'({busy, done}), W'(0));
            @(negedge clk);
            rst = 1'b0;
            repeat (60) begin @(negedge clk); if (done) dcnt++; end
            chk("mid_reset no_done", W'(dcnt), W'(0));
            chk("mid_reset held", state_out, '0);
        end
        mstate = '0;

        for (int i = 0; i < 20; i++) begin
            logic ld, inv;
            logic [4:0] np;
            logic [W-1:0] sin;
            ld  = ($urandom % 4) != 0;
            inv = 1'($urandom);
            np  = (i == 7) ? 5'd31 : 5'($urandom_range(0, 5));
            for (int k = 0; k < 25; k++) sin[k*LW +: LW] = LW'($urandom);
            if (ld) mstate = sin;
            mstate = pi_model(mstate, inv, int'(np));
            run_op($sformatf("rand%0d", i), ld, inv, np, sin, mstate);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
